// File: rtl/base64_encoder_ctrl_if.sv
// Byte-in / character-out handshake bundle for the Base64 encoder controller.
// The master is the source/sink side; the slave is the encoder.
interface base64_encoder_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_char, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_char, out_valid, out_last
  );
endinterface

// File: rtl/base64_encoder_ctrl.sv
// Streaming Base64 encoder: gathers 3-byte groups, then walks the four sextets
// through one shared RFC 4648 lookup, padding short final groups.
module base64_encoder_ctrl #(
  parameter logic [7:0] PAD_CHAR = 8'h3D,
  parameter int         CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  base64_encoder_ctrl_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     char_count
);
  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       byte_cnt_reg, byte_cnt_next;
  logic [23:0]      grp_reg, grp_next;
  logic [1:0]       nbytes_reg, nbytes_next;
  logic             lastgrp_reg, lastgrp_next;
  logic [1:0]       idx_reg, idx_next;
  logic [7:0]       out_char_reg, out_char_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_last_reg, out_last_next;
  logic [CNT_W-1:0] char_count_reg, char_count_next;

  logic        in_ready_int, in_fire, out_fire, group_done;
  logic [23:0] lut_src;
  logic [1:0]  lut_pos, lut_nbytes;
  logic [5:0]  lut_num;
  logic [7:0]  lut_hex, char_sel;
  logic        pad;
  logic [5:0]  sextet [4];

  function automatic logic [7:0] b64_lut(input logic [5:0] num);
    if (num < 6'd26)       return 8'h41 + {2'b00, num};
    else if (num < 6'd52)  return 8'h47 + {2'b00, num};
    else if (num < 6'd62)  return 8'hFC + {2'b00, num};
    else if (num == 6'd62) return 8'h2B;
    else                   return 8'h2F;
  endfunction

  assign in_ready_int = (state_reg == COLLECT) & ~rst;
  assign in_fire      = bus.in_valid & in_ready_int;
  assign out_fire     = out_valid_reg & bus.out_ready;
  assign group_done   = in_fire & ((byte_cnt_reg == 2'd2) | bus.in_last);

  // On the entry edge the lookup sees the group being completed; in EMIT it
  // looks one character ahead so the next char is ready at the handshake.
  assign lut_src    = (state_reg == COLLECT) ? grp_next    : grp_reg;
  assign lut_pos    = (state_reg == COLLECT) ? 2'd0        : idx_reg + 2'd1;
  assign lut_nbytes = (state_reg == COLLECT) ? nbytes_next : nbytes_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sextet
    assign sextet[gi] = lut_src[23-6*gi -: 6];
  end

  assign lut_num  = sextet[lut_pos];
  assign lut_hex  = b64_lut(lut_num);
  assign pad      = ((lut_pos == 2'd2) && (lut_nbytes < 2'd2)) ||
                    ((lut_pos == 2'd3) && (lut_nbytes < 2'd3));
  assign char_sel = pad ? PAD_CHAR : lut_hex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= COLLECT;
      byte_cnt_reg   <= 2'd0;
      grp_reg        <= 24'd0;
      nbytes_reg     <= 2'd0;
      lastgrp_reg    <= 1'b0;
      idx_reg        <= 2'd0;
      out_char_reg   <= 8'd0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      char_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      grp_reg        <= grp_next;
      nbytes_reg     <= nbytes_next;
      lastgrp_reg    <= lastgrp_next;
      idx_reg        <= idx_next;
      out_char_reg   <= out_char_next;
      out_valid_reg  <= out_valid_next;
      out_last_reg   <= out_last_next;
      char_count_reg <= char_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    grp_next        = grp_reg;
    nbytes_next     = nbytes_reg;
    lastgrp_next    = lastgrp_reg;
    idx_next        = idx_reg;
    char_count_next = char_count_reg;
    case (state_reg)
      COLLECT: begin
        if (in_fire) begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
          case (byte_cnt_reg)
            2'd0:    grp_next[23:16] = bus.in_data;
            2'd1:    grp_next[15:8]  = bus.in_data;
            default: grp_next[7:0]   = bus.in_data;
          endcase
          if (group_done) begin
            state_next   = EMIT;
            nbytes_next  = byte_cnt_reg + 2'd1;
            lastgrp_next = bus.in_last;
            idx_next     = 2'd0;
            // Bytes that never arrived encode as zero bits
            if (byte_cnt_reg == 2'd0) grp_next[15:8] = 8'd0;
            if (byte_cnt_reg <= 2'd1) grp_next[7:0]  = 8'd0;
          end
        end
      end
      default: begin
        if (out_fire) begin
          char_count_next = char_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          if (idx_reg == 2'd3) begin
            state_next    = COLLECT;
            byte_cnt_next = 2'd0;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    out_char_next  = out_char_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    case (state_reg)
      COLLECT: begin
        if (group_done) begin
          out_char_next  = char_sel;
          out_valid_next = 1'b1;
          out_last_next  = 1'b0;
        end
      end
      default: begin
        if (out_fire) begin
          if (idx_reg == 2'd3) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end else begin
            out_char_next = char_sel;
            out_last_next = (idx_reg == 2'd2) & lastgrp_reg;
          end
        end
      end
    endcase
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_char  = out_char_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign busy          = (state_reg == EMIT) | (byte_cnt_reg != 2'd0);
  assign char_count    = char_count_reg;
endmodule

// File: tb/tb_base64_encoder_ctrl.sv
// Bench for base64_encoder_ctrl: directed and random messages scored against
// a plain arithmetic Base64 model, plus reset and backpressure checks.
module tb_base64_encoder_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] char_count;

  base64_encoder_ctrl_if bus();

  base64_encoder_ctrl #(.PAD_CHAR(8'h3D), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_count = 0;
  byte unsigned pend[$];
  byte unsigned msg_q[$];
  logic [7:0]   exp_q[$];
  bit           exp_last_q[$];
  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: standard Base64 of the pending message, '=' padding, last flag on final char
  task automatic load();
    int n;
    n = pend.size();
    for (int g = 0; g < n; g += 3) begin
      int k;
      int v;
      k = (n - g >= 3) ? 3 : n - g;
      v = int'(pend[g]) << 16;
      if (k > 1) v = v | (int'(pend[g+1]) << 8);
      if (k > 2) v = v | int'(pend[g+2]);
      for (int c = 0; c < 4; c++) begin
        if (c <= k) exp_q.push_back(8'(alpha[(v >> (18 - 6*c)) & 63]));
        else        exp_q.push_back(8'h3D);
        exp_last_q.push_back((g + 3 >= n) && (c == 3));
      end
    end
    foreach (pend[i]) msg_q.push_back(pend[i]);
    $display("msg: %0d bytes -> %0d chars", n, exp_q.size());
    pend.delete();
  endtask

  // ready_mode: 0 always ready, 1 random, 2 repeating 1-0-0-1
  task automatic run(input int ready_mode, input int gap_pct);
    int  cyc;
    int  grp_n;
    int  rpat;
    bit  expect_valid_next;
    bit  stall;
    logic [7:0] held_c;
    logic       held_l;
    cyc = 0; grp_n = 0; rpat = 0; expect_valid_next = 0; stall = 0;
    held_c = 8'd0; held_l = 1'b0;
    while ((msg_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      if (msg_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = msg_q[0];
        bus.in_last  = (msg_q.size() == 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
      end
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(1));
        default: bus.out_ready = (rpat % 4 == 0) || (rpat % 4 == 3);
      endcase
      rpat++;
      @(negedge clk);
      if (expect_valid_next) check("latency_valid", bus.out_valid, 1);
      if (stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_char", bus.out_char, held_c);
        check("hold_last", bus.out_last, held_l);
      end
      check("in_ready_vs_emit", bus.in_ready, !bus.out_valid);
      expect_valid_next = 0;
      if (bus.in_valid && bus.in_ready) begin
        grp_n++;
        if (grp_n == 3 || bus.in_last) begin
          expect_valid_next = 1;
          grp_n = 0;
        end
        void'(msg_q.pop_front());
      end
      stall  = bus.out_valid && !bus.out_ready;
      held_c = bus.out_char;
      held_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_valid", bus.out_valid, 0);
        else begin
          check("char", bus.out_char, exp_q.pop_front());
          check("last", bus.out_last, exp_last_q.pop_front());
          model_count++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("drain_left", msg_q.size() + exp_q.size(), 0);
    @(negedge clk);
    check("char_count", 32'(char_count), 32'(model_count % (1 << CNT_W)));
    check("idle_busy", busy, 0);
    check("idle_valid", bus.out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_data = 8'd0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_char", bus.out_char, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_char_count", 32'(char_count), 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    pend = '{8'h4D, 8'h61, 8'h6E};                 load(); run(0, 0);
    pend = '{8'h4D, 8'h61};                        load(); run(0, 0);
    pend = '{8'h4D};                               load(); run(0, 0);
    pend = '{8'h4D, 8'h61, 8'h6E, 8'h4D, 8'h61};   load(); run(2, 0);
    pend = '{8'hFF, 8'hFF, 8'hFF};                 load(); run(0, 0);
    pend = '{8'h00, 8'h00, 8'h00};                 load(); run(1, 0);

    for (int m = 0; m < 20; m++) begin
      int len;
      len = $urandom_range(1, 11);
      for (int b = 0; b < len; b++) pend.push_back(8'($urandom));
      load();
      run(1, 30);
    end

    // Partial group without in_last waits, then reset discards it
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("partial_busy", busy, 1);
    check("partial_in_ready", bus.in_ready, 1);
    check("partial_valid", bus.out_valid, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst2_busy", busy, 0);
    check("rst2_in_ready", bus.in_ready, 0);
    check("rst2_char_count", 32'(char_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_count = 0;

    // Reset while EMIT sits at idx=2
    send_byte(8'h4D, 1'b0);
    send_byte(8'h61, 1'b0);
    send_byte(8'h6E, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_emit_char", bus.out_char, 8'h46);
    #2;
    rst = 1'b1;
    #1;
    check("rst3_out_valid", bus.out_valid, 0);
    check("rst3_out_char", bus.out_char, 0);
    check("rst3_out_last", bus.out_last, 0);
    check("rst3_char_count", 32'(char_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_count = 0;
    pend = '{8'h4D, 8'h61, 8'h6E};
    load();
    run(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/base64_encoder_ctrl.md
Name: base64_encoder_ctrl

Overview:
Streaming Base64 encoder controller that sequences the base64 sextet-to-ASCII lookup.
- Collects input bytes into 3-byte groups and splits each group into four 6-bit sextets.
- Presents each sextet to a single shared base64 lookup instance (num in, hex out) and emits one ASCII character per handshake.
- Pads short final groups with '='.
- Sits between a byte source (UART RX / memory reader) and a character sink (UART TX / display buffer).

Parameters:
- PAD_CHAR, 8'h3D, ASCII code emitted for padding positions ('=').
- CNT_W, 16, width of the emitted-character counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  input byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the current byte as the last byte of the message.
- in_ready  output  1  controller accepts a byte this cycle.
- out_char  output  8  ASCII character (registered).
- out_valid  output  1  out_char valid (registered).
- out_last  output  1  out_char is the final character of the message (registered).
- out_ready  input  1  sink accepts out_char this cycle.
- busy  output  1  high in EMIT or when a partial group is held.
- char_count  output  CNT_W  characters emitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert): state=COLLECT, byte_cnt=0, group buffer=0, out_char=0, out_valid=0, out_last=0, char_count=0. in_ready is 0 while rst is high.
- States: COLLECT, EMIT.
- COLLECT:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready, the byte is stored: byte 0 → buf[23:16], byte 1 → buf[15:8], byte 2 → buf[7:0]. byte_cnt increments.
  - Transition to EMIT on the same edge when the 3rd byte is accepted (nbytes=3), or when any byte is accepted with in_last=1 (nbytes=byte_cnt+1).
  - On that transition, bytes not received are zeroed in buf.
  - lastgrp is latched from in_last.
- EMIT:
  - in_ready=0. Character index idx runs 0..3.
  - Sextets: s0=buf[23:18], s1=buf[17:12], s2=buf[11:6], s3=buf[5:0].
  - Characters: char0=LUT(s0); char1=LUT(s1); char2=LUT(s2) if nbytes≥2 else PAD_CHAR; char3=LUT(s3) if nbytes=3 else PAD_CHAR.
  - LUT follows the RFC 4648 alphabet: 0-25 'A'-'Z', 26-51 'a'-'z', 52-61 '0'-'9', 62 '+', 63 '/'.
  - On the entry edge: out_char←char0, out_valid←1, idx←0.
  - Each out_valid & out_ready edge with idx<3: out_char←char(idx+1), idx++, char_count++.
  - Handshake at idx=3: out_valid←0, char_count++, byte_cnt←0, state←COLLECT.
  - out_last=1 only while idx=3 and lastgrp=1.
- Latency: first character is valid on the cycle after the group-completing byte is accepted.
- Peak rate: 3 input bytes per 3 collect + 4 emit cycles. No overlap of COLLECT and EMIT.
- out_char, out_valid and out_last are held stable while out_valid & !out_ready (backpressure of any length).
- in_valid while in_ready=0 is ignored; the source must hold the byte.
- Empty message: in_last with no byte is not possible; in_last is only meaningful with in_valid.
- A partial group (byte_cnt 1-2) without in_last waits indefinitely in COLLECT.
- Reset mid-EMIT or mid-group discards all pending data and characters; no output on the next cycle.
- char_count wraps from 2^CNT_W-1 to 0 with no flag.
- busy = (state==EMIT) | (byte_cnt≠0).

Test Plan:
- "Man" (4D,61,6E) with last on 6E, out_ready=1 → out_char 54,57,46,75 ("TWFu") on 4 consecutive cycles starting 1 cycle after 6E; out_last on 75; char_count=4.
- "Ma" (4D,61 last) → 54,57,45,3D ("TWE="); out_last on 3D.
- "M" (4D last) → 54,51,3D,3D ("TQ=="); in_ready low for 4 cycles, then high.
- "Man" followed by "Ma"(last), out_ready toggling 1-0-0-1 → out_char/out_valid held through stalls; sequence 54,57,46,75,54,57,45,3D; out_last only on the final 3D.
- Bytes FF,FF,FF(last) → 2F,2F,2F,2F ("////"). Bytes 00,00,00(last) → 41 ×4 ("AAAA").
- Assert rst after 2 bytes, and again mid-EMIT at idx=2 → outputs zero immediately; next "Man" encodes as "TWFu" with char_count restarting from 0.
